// File: rtl/alu_pkg.sv
// Shared ALU definitions used by the ALU decoder and the execute pipeline.
package alu_pkg;

  localparam int unsigned XlenDefault = 32;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011,
    AluSlt = 3'b100
  } alu_op_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU datapath. Codes with no defined operation yield 0.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      op,
  output logic [XLEN-1:0] result
);

  // Select the operation; ADD/SUB wrap naturally at XLEN bits.
  always_comb begin
    result = '0;
    case (op)
      AluAdd:  result = a + b;
      AluSub:  result = a - b;
      AluAnd:  result = a & b;
      AluOr:   result = a | b;
      AluSlt:  result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/ex_pipe.sv
// Two-stage execute pipeline: S1 captures operands, S2 holds the registered
// ALU result. Valid/ready handshake on both sides, flush kills S1 only.
module ex_pipe
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XlenDefault
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic [2:0]      alu_control,
  input  logic [4:0]      rd,
  input  logic            reg_write,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic [4:0]      out_rd,
  output logic            out_reg_write
);

  logic            s1_valid_q;
  logic [XLEN-1:0] s1_a_q;
  logic [XLEN-1:0] s1_b_q;
  logic [2:0]      s1_op_q;
  logic [4:0]      s1_rd_q;
  logic            s1_rw_q;

  logic            s2_valid_q;
  logic [XLEN-1:0] s2_result_q;
  logic            s2_zero_q;
  logic [4:0]      s2_rd_q;
  logic            s2_rw_q;

  logic            s2_load;
  logic            s1_adv;
  logic            in_fire;
  logic            s1_keep;
  logic [XLEN-1:0] alu_out;

  alu_core #(
    .XLEN(XLEN)
  ) u_alu_core (
    .a      (s1_a_q),
    .b      (s1_b_q),
    .op     (s1_op_q),
    .result (alu_out)
  );

  // Handshake decode; reset forces in_ready low while it is asserted.
  always_comb begin
    s2_load  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_load;
    in_ready = (!s1_valid_q || s1_adv) && !flush && !reset;
    in_fire  = in_valid && in_ready;
    // An op leaving S1 under flush is discarded rather than loaded into S2.
    s1_keep  = s1_valid_q && !flush;
  end

  // S1: capture accepted operands, empty on advance or flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s1_rd_q    <= '0;
      s1_rw_q    <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
      s1_a_q     <= src_a;
      s1_b_q     <= src_b;
      s1_op_q    <= alu_control;
      s1_rd_q    <= rd;
      s1_rw_q    <= reg_write;
    end else if (s1_adv || flush) begin
      s1_valid_q <= 1'b0;
    end
  end

  // S2: load when empty or draining; data only changes on a real advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b1;
      s2_rd_q     <= '0;
      s2_rw_q     <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_keep;
      if (s1_keep) begin
        s2_result_q <= alu_out;
        s2_zero_q   <= (alu_out == '0);
        s2_rd_q     <= s1_rd_q;
        s2_rw_q     <= s1_rw_q;
      end
    end
  end

  // Output drive; reg_write is masked whenever nothing is presented.
  always_comb begin
    out_valid     = s2_valid_q;
    alu_result    = s2_result_q;
    zero          = s2_zero_q;
    out_rd        = s2_rd_q;
    out_reg_write = s2_valid_q && s2_rw_q;
  end

endmodule

// File: tb/tb_ex_pipe.sv
// Scoreboard bench for ex_pipe: directed corner cases plus randomized traffic.
module tb_ex_pipe;
  import alu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic [2:0]      alu_control;
  logic [4:0]      rd;
  logic            reg_write;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] alu_result;
  logic            zero;
  logic [4:0]      out_rd;
  logic            out_reg_write;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  bit          hold_pending = 1'b0;
  logic [31:0] h_res;
  logic        h_zero;
  logic [4:0]  h_rd;
  logic        h_rw;
  bit          done = 1'b0;

  always #5 clk = ~clk;

  ex_pipe #(
    .XLEN(XLEN)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .src_a         (src_a),
    .src_b         (src_b),
    .alu_control   (alu_control),
    .rd            (rd),
    .reg_write     (reg_write),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alu_result    (alu_result),
    .zero          (zero),
    .out_rd        (out_rd),
    .out_reg_write (out_reg_write)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", name, got, want);
    end
  endtask

  // Reference ALU from the operation table, using plain integer arithmetic.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Present one op starting at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] r, input logic w);
    bit   ok;
    exp_t x;
    ok          = 1'b0;
    in_valid    = 1'b1;
    alu_control = op;
    src_a       = a;
    src_b       = b;
    rd          = r;
    reg_write   = w;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 32'd1);
    if (ok) begin
      x.res = ref_alu(op, a, b);
      x.rd  = r;
      x.rw  = w;
      exp_q.push_back(x);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: pops on every output transfer and checks stall stability.
  always @(negedge clk) begin
    if (reset) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_result", alu_result, h_res);
        chk("hold_zero", 32'(zero), 32'(h_zero));
        chk("hold_rd", 32'(out_rd), 32'(h_rd));
        chk("hold_rw", 32'(out_reg_write), 32'(h_rw));
      end
      if (!out_valid) chk("rw_idle", 32'(out_reg_write), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got 0x%08h want none", alu_result);
        end else begin
          e = exp_q.pop_front();
          chk("result", alu_result, e.res);
          chk("zero", 32'(zero), 32'(e.res == 32'd0));
          chk("out_rd", 32'(out_rd), 32'(e.rd));
          chk("out_rw", 32'(out_reg_write), 32'(e.rw));
        end
      end
      hold_pending = out_valid && !out_ready;
      h_res  = alu_result;
      h_zero = zero;
      h_rd   = out_rd;
      h_rw   = out_reg_write;
    end
  end

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    src_a       = '0;
    src_b       = '0;
    alu_control = '0;
    rd          = '0;
    reg_write   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);
    chk("post_rst_zero", 32'(zero), 32'd1);
    chk("post_rst_result", alu_result, 32'd0);
    chk("post_rst_rw", 32'(out_reg_write), 32'd0);
    @(posedge clk);
    #1;

    // Latency: accepted at edge N, visible after edge N+1.
    out_ready = 1'b1;
    send(3'd0, 32'h7FFF_FFFF, 32'h0000_0001, 5'd3, 1'b1);
    @(negedge clk);
    chk("lat_edge_n", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_edge_n1", 32'(out_valid), 32'd1);
    chk("lat_result", alu_result, 32'h8000_0000);
    @(posedge clk);
    #1;

    send(3'd1, 32'h0000_0005, 32'h0000_0005, 5'd4, 1'b1);
    send(3'd4, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5, 1'b0);
    send(3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 1'b1);
    send(3'd4, 32'h0000_0001, 32'hFFFF_FFFF, 5'd7, 1'b1);
    drain();

    // Backpressure: two ops buffered, third blocked for three cycles.
    out_ready = 1'b0;
    send(3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd8, 1'b1);
    send(3'd3, 32'h0000_1000, 32'h0000_0001, 5'd9, 1'b1);
    in_valid    = 1'b1;
    alu_control = 3'd0;
    src_a       = 32'd10;
    src_b       = 32'd20;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(3'd0, 32'd10, 32'd20, 5'd10, 1'b1);
    send(3'd1, 32'd0, 32'd1, 5'd11, 1'b0);
    drain();

    // Flush with S1=A, S2=B, both with S2 held and with S2 draining.
    for (int r = 0; r < 2; r++) begin
      out_ready = r[0];
      send(3'd0, 32'd100, 32'd1, 5'd12, 1'b1);
      send(3'd0, 32'd200, 32'd2, 5'd13, 1'b1);
      flush    = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      void'(exp_q.pop_back());
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("flush_empty_q", 32'(exp_q.size()), 32'd0);
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    // Reset with both stages full drops everything.
    out_ready = 1'b0;
    send(3'd1, 32'd7, 32'd3, 5'd14, 1'b1);
    send(3'd0, 32'd1, 32'd1, 5'd15, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_full_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("rst_full_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full_zero", 32'(zero), 32'd1);
    chk("rst_full_rw", 32'(out_reg_write), 32'd0);
    chk("rst_full_in_ready2", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Randomized traffic with random downstream backpressure.
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          send(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom), 1'($urandom));
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_pipe.md
EX_PIPE -- requirements
Module: ex_pipe

Interface
REQ-001 Parameter: XLEN, default 32, operand and result width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  upstream (decode) presents an operation.
REQ-005 in_ready  output  1  block accepts the operation this cycle.
REQ-006 src_a  input  XLEN  operand A.
REQ-007 src_b  input  XLEN  operand B (register or immediate, already muxed).
REQ-008 alu_control  input  3  ALU op from the ALU decoder.
REQ-009 rd  input  5  destination register index, passed through.
REQ-010 reg_write  input  1  write-enable, passed through.
REQ-011 flush  input  1  kill the operation held in stage 1.
REQ-012 out_valid  output  1  result available downstream.
REQ-013 out_ready  input  1  downstream accepts the result.
REQ-014 alu_result  output  XLEN  computed result.
REQ-015 zero  output  1  high when alu_result equals 0.
REQ-016 out_rd  output  5  rd of the presented result.
REQ-017 out_reg_write  output  1  reg_write of the presented result.

Function
REQ-018 Two register stages SHALL be used: S1 captures the operands, S2 holds the registered ALU result.
REQ-019 An input transfer SHALL occur when in_valid && in_ready at a rising edge.
REQ-020 An output transfer SHALL occur when out_valid && out_ready at a rising edge.
REQ-021 S2 SHALL load when S2 is empty or out_ready is high. S1 SHALL advance into S2 only under that same condition.
REQ-022 in_ready SHALL equal (!s1_valid || s1 advances) && !flush, computed combinationally.
REQ-023 Latency SHALL be 2 cycles: an operation accepted at edge N appears on out_valid after edge N+1 when no stall occurs.
REQ-024 Sustained throughput SHALL be one operation per cycle while out_ready stays high.
REQ-025 ALU encodings: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT.
REQ-026 ADD and SUB SHALL wrap modulo 2^XLEN, with no overflow flag.
REQ-027 SLT SHALL compare the operands as signed two's complement and produce 1 or 0, zero-extended to XLEN.
REQ-028 Codes 101, 110 and 111 SHALL produce a result of 0, with no error indication.
REQ-029 zero SHALL be registered together with alu_result and SHALL be consistent with it.
REQ-030 While out_valid && !out_ready, all outputs SHALL hold stable.
REQ-031 With out_valid low, the data outputs are don't-care. out_reg_write SHALL be 0 in that case.
REQ-032 flush SHALL clear s1_valid at the edge and SHALL leave S2 untouched.
REQ-033 An operation simultaneously advancing from S1 to S2 under flush SHALL be discarded, so S2 becomes empty unless it is held.
REQ-034 While flush is high, no input transfer SHALL occur.
REQ-035 When S2 drains while S1 is full and a new input arrives in the same cycle, all three moves SHALL complete in that cycle without loss.

Reset
REQ-036 reset SHALL clear s1_valid and s2_valid, so that out_valid = 0, in_ready = 0 during reset, and in_ready = 1 on the first cycle after reset.
REQ-037 On reset, alu_result, out_rd and out_reg_write SHALL go to 0 and zero SHALL go to 1.
REQ-038 reset SHALL take priority over flush and handshakes. An in-flight operation is dropped.

Structure
REQ-039 alu_pkg SHALL hold the alu_op_e enum (ADD, SUB, AND, OR, SLT) and the XLEN default. The ALU decoder and this block SHALL share it.
REQ-040 Sub-module alu_core SHALL contain the purely combinational result computation. ex_pipe SHALL own all registers and handshakes.

Verification
REQ-041 ADD with 0x7FFFFFFF and 0x00000001, out_ready=1 -> alu_result=0x80000000, zero=0, two cycles after accept.
REQ-042 SUB with 0x00000005 and 0x00000005 -> alu_result=0, zero=1. SLT with 0xFFFFFFFF and 0x00000001 -> alu_result=1.
REQ-043 Stream 4 back-to-back ops, hold out_ready=0 for 3 cycles -> outputs stable, in_ready falls after two ops are buffered, no loss or reordering.
REQ-044 Assert flush in the cycle after accepting op A with S2 holding op B -> B still delivered, A never appears, in_ready=0 in the flush cycle.
REQ-045 Assert reset with both stages full -> next cycle out_valid=0, zero=1, out_reg_write=0, in_ready=1 once reset drops.
REQ-046 Code 110 with src_a=0xFFFFFFFF and src_b=0xFFFFFFFF -> alu_result=0, zero=1.
